// File: rtl/spi_slave_sram_bridge.sv
// ---------------------------------------------------------------------------
// spi_slave_sram_bridge
//
// Glue between a byte-oriented SPI slave and a word-oriented SRAM controller.
//
// Write direction: received bytes are packed big-endian into 16-bit words and
// queued. A request FSM hands the queue head to the controller with a level
// request (sram_write) and holds it until the controller pulses sram_hint.
//
// Read direction: when the transmit byte buffer is empty and the controller
// has data (fifo_o_empty low), the FSM raises sram_read. On completion the
// 16-bit word is buffered and handed back to the SPI slave one byte per
// tx_req, high byte first.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   rx_byte, rx_valid  byte stream from the SPI slave
//   rx_flush           pad a pending odd byte with 8'h00 and queue it
//   tx_req             SPI slave wants its next byte
//   tx_byte, tx_valid  byte answer, one cycle after tx_req
//   sram_write/read    level requests to the controller
//   sram_wdata         word being written
//   sram_rdata         word returned by a read
//   sram_hint          one-cycle completion pulse from the controller
//   fifo_i_full        controller cannot accept writes
//   fifo_o_empty       controller has nothing to read
//   clr_err            clears the sticky error flags
//   err_overflow       a packed word was dropped because the queue was full
//   err_underrun       tx_req arrived with nothing buffered
//   err_timeout        a request was abandoned after HINT_TIMEOUT cycles
// ---------------------------------------------------------------------------
module spi_slave_sram_bridge #(
  parameter int WQ_DEPTH     = 4,
  parameter int HINT_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_flush,
  input  logic        tx_req,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  output logic        sram_write,
  output logic        sram_read,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  input  logic        sram_hint,
  input  logic        fifo_i_full,
  input  logic        fifo_o_empty,
  input  logic        clr_err,
  output logic        err_overflow,
  output logic        err_underrun,
  output logic        err_timeout
);

  localparam int PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(WQ_DEPTH + 1);
  localparam int TMO_W = (HINT_TIMEOUT > 1) ? $clog2(HINT_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT,
    ABORT
  } state_t;

  state_t state;

  // Byte packer state: holds the first byte of a word until its partner
  logic        pend_valid;
  logic [7:0]  pend_byte;
  logic        push;
  logic [15:0] push_word;

  // Write-word queue
  logic [15:0]      wq_mem [WQ_DEPTH];
  logic [PTR_W-1:0] wq_wr_ptr;
  logic [PTR_W-1:0] wq_rd_ptr;
  logic [CNT_W-1:0] wq_count;
  logic             wq_full;
  logic             wq_empty;
  logic             push_ok;
  logic             pop;
  logic [15:0]      wq_head;

  // Transmit byte buffer: number of bytes still to hand out (0..2)
  logic [15:0] buf_word;
  logic [1:0]  buf_cnt;

  // Request FSM bookkeeping
  logic             prefer_wr;
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_wait;
  logic             wr_done;
  logic             rd_done;
  logic             tmo_hit;
  logic             wr_elig;
  logic             rd_elig;

  // Error events for the sticky flags
  logic overflow_evt;
  logic underrun_evt;
  logic timeout_evt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(WQ_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Packing decision. A byte completing a word always wins; a flush that
  // arrives with the first byte of a word pads that byte immediately, and a
  // flush on its own only acts when an odd byte is waiting.
  always_comb begin
    push      = 1'b0;
    push_word = 16'h0000;
    if (rx_valid && pend_valid) begin
      push      = 1'b1;
      push_word = {pend_byte, rx_byte};
    end else if (rx_valid && rx_flush) begin
      push      = 1'b1;
      push_word = {rx_byte, 8'h00};
    end else if (!rx_valid && rx_flush && pend_valid) begin
      push      = 1'b1;
      push_word = {pend_byte, 8'h00};
    end
  end

  // Pending odd byte register; cleared whenever a word leaves the packer
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_byte  <= 8'h00;
    end else if (rx_valid) begin
      if (pend_valid || rx_flush) begin
        pend_valid <= 1'b0;
      end else begin
        pend_valid <= 1'b1;
        pend_byte  <= rx_byte;
      end
    end else if (rx_flush) begin
      pend_valid <= 1'b0;
    end
  end

  // Queue status. A pop in the same cycle frees the slot, so a push onto a
  // full queue is only dropped when nothing leaves.
  assign wq_full      = (wq_count == CNT_W'(WQ_DEPTH));
  assign wq_empty     = (wq_count == '0);
  assign wq_head      = wq_mem[wq_rd_ptr];
  assign pop          = wr_done;
  assign push_ok      = push && (!wq_full || pop);
  assign overflow_evt = push && wq_full && !pop;

  // Queue storage carries no reset; validity is tracked by wq_count
  always_ff @(posedge clk) begin
    if (push_ok) begin
      wq_mem[wq_wr_ptr] <= push_word;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wq_wr_ptr <= '0;
      wq_rd_ptr <= '0;
      wq_count  <= '0;
    end else begin
      if (push_ok) begin
        wq_wr_ptr <= ptr_inc(wq_wr_ptr);
      end
      if (pop) begin
        wq_rd_ptr <= ptr_inc(wq_rd_ptr);
      end
      case ({push_ok, pop})
        2'b10:   wq_count <= wq_count + CNT_W'(1);
        2'b01:   wq_count <= wq_count - CNT_W'(1);
        default: wq_count <= wq_count;
      endcase
    end
  end

  // Completion and timeout are only meaningful while a request is out;
  // a hint seen in IDLE or ABORT falls through these terms unused.
  assign in_wait     = (state == WR_WAIT) || (state == RD_WAIT);
  assign wr_done     = (state == WR_WAIT) && sram_hint;
  assign rd_done     = (state == RD_WAIT) && sram_hint;
  assign tmo_hit     = (tmo_cnt == TMO_W'(HINT_TIMEOUT - 1));
  assign timeout_evt = in_wait && !sram_hint && tmo_hit;

  // Reads are only started into an empty byte buffer so a loaded word is
  // never overwritten before the SPI side has drained it.
  assign wr_elig = !wq_empty && !fifo_i_full;
  assign rd_elig = (buf_cnt == 2'd0) && !fifo_o_empty;

  // Request FSM. Requests and write data are registered here and held
  // untouched for the whole wait. Every grant points the arbiter at the
  // other kind, so contending writes and reads alternate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sram_write <= 1'b0;
      sram_read  <= 1'b0;
      sram_wdata <= 16'h0000;
      prefer_wr  <= 1'b1;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (wr_elig && (!rd_elig || prefer_wr)) begin
            state      <= WR_WAIT;
            sram_write <= 1'b1;
            sram_wdata <= wq_head;
            prefer_wr  <= 1'b0;
          end else if (rd_elig) begin
            state     <= RD_WAIT;
            sram_read <= 1'b1;
            prefer_wr <= 1'b1;
          end
        end
        WR_WAIT, RD_WAIT: begin
          if (sram_hint) begin
            state      <= IDLE;
            sram_write <= 1'b0;
            sram_read  <= 1'b0;
            tmo_cnt    <= '0;
          end else if (tmo_hit) begin
            state      <= ABORT;
            sram_write <= 1'b0;
            sram_read  <= 1'b0;
            tmo_cnt    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ABORT: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          sram_write <= 1'b0;
          sram_read  <= 1'b0;
        end
      endcase
    end
  end

  // Transmit side. A read completing in the same cycle as tx_req answers
  // straight from the incoming word, leaving only its low byte buffered.
  assign underrun_evt = tx_req && !rd_done && (buf_cnt == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_word <= 16'h0000;
      buf_cnt  <= 2'd0;
      tx_byte  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= tx_req;
      if (rd_done) begin
        buf_word <= sram_rdata;
        if (tx_req) begin
          tx_byte <= sram_rdata[15:8];
          buf_cnt <= 2'd1;
        end else begin
          buf_cnt <= 2'd2;
        end
      end else if (tx_req) begin
        case (buf_cnt)
          2'd2: begin
            tx_byte <= buf_word[15:8];
            buf_cnt <= 2'd1;
          end
          2'd1: begin
            tx_byte <= buf_word[7:0];
            buf_cnt <= 2'd0;
          end
          default: begin
            tx_byte <= 8'h00;
          end
        endcase
      end
    end
  end

  // Sticky error flags: a new event in the clearing cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow <= 1'b0;
      err_underrun <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_overflow <= (err_overflow && !clr_err) || overflow_evt;
      err_underrun <= (err_underrun && !clr_err) || underrun_evt;
      err_timeout  <= (err_timeout  && !clr_err) || timeout_evt;
    end
  end

endmodule

// File: tb/tb_spi_slave_sram_bridge.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_sram_bridge
//
// Self-checking bench for spi_slave_sram_bridge. Words expected on the SRAM
// write port and bytes expected on tx_byte are queued when the stimulus that
// produces them is driven, and popped when the DUT presents them. The bench
// plays the SRAM controller by answering requests with sram_hint pulses.
// ---------------------------------------------------------------------------
module tb_spi_slave_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_flush;
  logic        tx_req;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        sram_write;
  logic        sram_read;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_hint;
  logic        fifo_i_full;
  logic        fifo_o_empty;
  logic        clr_err;
  logic        err_overflow;
  logic        err_underrun;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;
  bit mutex_viol = 1'b0;

  logic [15:0] exp_wq[$];
  logic [7:0]  exp_tx[$];

  spi_slave_sram_bridge #(
    .WQ_DEPTH    (4),
    .HINT_TIMEOUT(64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_flush    (rx_flush),
    .tx_req      (tx_req),
    .tx_byte     (tx_byte),
    .tx_valid    (tx_valid),
    .sram_write  (sram_write),
    .sram_read   (sram_read),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .sram_hint   (sram_hint),
    .fifo_i_full (fifo_i_full),
    .fifo_o_empty(fifo_o_empty),
    .clr_err     (clr_err),
    .err_overflow(err_overflow),
    .err_underrun(err_underrun),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // The two requests must never be high together
  always @(negedge clk) begin
    if (rst === 1'b0 && sram_write === 1'b1 && sram_read === 1'b1) begin
      mutex_viol = 1'b1;
    end
  end

  // Hard stop if something hangs
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flush);
    rx_byte  = b;
    rx_valid = 1'b1;
    rx_flush = flush;
    tick();
    rx_valid = 1'b0;
    rx_flush = 1'b0;
  endtask

  task automatic pulse_flush();
    rx_flush = 1'b1;
    tick();
    rx_flush = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic hint_pulse();
    sram_hint = 1'b1;
    tick();
    sram_hint = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits a bounded number of cycles for either request to appear
  task automatic wait_any(input int limit, output bit seen, output bit is_wr);
    seen  = 1'b0;
    is_wr = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (sram_write === 1'b1 || sram_read === 1'b1) begin
        seen  = 1'b1;
        is_wr = (sram_write === 1'b1);
        break;
      end
      tick();
    end
  endtask

  // Acts as the controller for one write: capture the data, then complete it
  task automatic serve_write(output bit seen, output bit is_wr, output logic [15:0] data);
    data = 16'h0000;
    wait_any(12, seen, is_wr);
    if (seen && is_wr) begin
      data = sram_wdata;
      hint_pulse();
    end
  endtask

  function automatic logic [15:0] pop_wq();
    if (exp_wq.size() == 0) return 16'hxxxx;
    return exp_wq.pop_front();
  endfunction

  function automatic logic [7:0] pop_tx();
    if (exp_tx.size() == 0) return 8'hxx;
    return exp_tx.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    sram_hint = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sram_hint = 1'b0;
    total++; if (sram_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_write: got %b want 0", sram_write); end
    total++; if (sram_read !== 1'b0) begin bad++; $display("[TB] FAIL reset_read: got %b want 0", sram_read); end
    total++; if (sram_wdata !== 16'h0000) begin bad++; $display("[TB] FAIL reset_wdata: got %h want 0000", sram_wdata); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx_valid: got %b want 0", tx_valid); end
    total++; if (tx_byte !== 8'h00) begin bad++; $display("[TB] FAIL reset_tx_byte: got %h want 00", tx_byte); end
    total++; if ({err_overflow, err_underrun, err_timeout} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_errs: got %b want 000", {err_overflow, err_underrun, err_timeout});
    end
  endtask

  task automatic test_write_handshake();
    bit seen, is_wr;
    logic [15:0] exp;
    fifo_i_full = 1'b1;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    exp_wq.push_back(16'hA53C);
    fifo_i_full = 1'b0;
    wait_any(10, seen, is_wr);
    total++; if ({seen, is_wr} !== 2'b11) begin bad++; $display("[TB] FAIL wr_grant: got %b want 11", {seen, is_wr}); end
    exp = pop_wq();
    total++; if (sram_wdata !== exp) begin bad++; $display("[TB] FAIL wr_data: got %h want %h", sram_wdata, exp); end
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (sram_write !== 1'b1 || sram_wdata !== exp) begin
        bad++; $display("[TB] FAIL wr_hold: got %b/%h want 1/%h", sram_write, sram_wdata, exp);
      end
    end
    hint_pulse();
    total++; if (sram_write !== 1'b0) begin bad++; $display("[TB] FAIL wr_drop: got %b want 0", sram_write); end
    tick();
    total++; if (sram_write !== 1'b0) begin bad++; $display("[TB] FAIL wr_gap: got %b want 0", sram_write); end
    fifo_i_full = 1'b1;
  endtask

  task automatic test_flush();
    bit seen, is_wr, any_wr;
    logic [15:0] d, exp;
    fifo_i_full = 1'b1;
    send_byte(8'h11, 1'b0);
    pulse_flush();
    exp_wq.push_back(16'h1100);
    pulse_flush();
    send_byte(8'h22, 1'b1);
    exp_wq.push_back(16'h2200);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    exp_wq.push_back(16'h3344);
    fifo_i_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      serve_write(seen, is_wr, d);
      exp = pop_wq();
      total++; if ({seen, is_wr} !== 2'b11 || d !== exp) begin
        bad++; $display("[TB] FAIL flush_word%0d: got %b/%h want 11/%h", i, {seen, is_wr}, d, exp);
      end
    end
    any_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sram_write === 1'b1) any_wr = 1'b1;
    end
    total++; if (any_wr !== 1'b0) begin bad++; $display("[TB] FAIL flush_extra_write: got %b want 0", any_wr); end
    fifo_i_full = 1'b1;
  endtask

  task automatic test_overflow();
    bit seen, is_wr;
    logic [15:0] d, exp;
    fifo_i_full = 1'b1;
    for (int w = 0; w < 5; w++) begin
      send_byte(8'hA0 + 8'(w), 1'b0);
      send_byte(8'h50 + 8'(w), 1'b0);
      if (w < 4) exp_wq.push_back({8'hA0 + 8'(w), 8'h50 + 8'(w)});
      if (w == 3) begin
        total++; if (err_overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_early: got %b want 0", err_overflow); end
      end
    end
    total++; if (err_overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set: got %b want 1", err_overflow); end
    pulse_clr();
    total++; if (err_overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clr: got %b want 0", err_overflow); end
    // Push onto the full queue in the same cycle the head is popped
    send_byte(8'hC7, 1'b0);
    fifo_i_full = 1'b0;
    wait_any(10, seen, is_wr);
    exp = pop_wq();
    total++; if ({seen, is_wr} !== 2'b11 || sram_wdata !== exp) begin
      bad++; $display("[TB] FAIL ovf_head: got %b/%h want 11/%h", {seen, is_wr}, sram_wdata, exp);
    end
    rx_byte   = 8'h8E;
    rx_valid  = 1'b1;
    sram_hint = 1'b1;
    tick();
    rx_valid  = 1'b0;
    sram_hint = 1'b0;
    exp_wq.push_back(16'hC78E);
    total++; if (err_overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_push_pop: got %b want 0", err_overflow); end
    for (int i = 0; i < 4; i++) begin
      serve_write(seen, is_wr, d);
      exp = pop_wq();
      total++; if ({seen, is_wr} !== 2'b11 || d !== exp) begin
        bad++; $display("[TB] FAIL ovf_drain%0d: got %b/%h want 11/%h", i, {seen, is_wr}, d, exp);
      end
    end
    fifo_i_full = 1'b1;
  endtask

  task automatic test_read_underrun();
    bit seen, is_wr;
    logic [7:0] eb;
    sram_rdata   = 16'hBEEF;
    fifo_o_empty = 1'b0;
    wait_any(10, seen, is_wr);
    total++; if ({seen, is_wr} !== 2'b10) begin bad++; $display("[TB] FAIL rd_grant: got %b want 10", {seen, is_wr}); end
    fifo_o_empty = 1'b1;
    hint_pulse();
    exp_tx.push_back(8'hBE);
    exp_tx.push_back(8'hEF);
    exp_tx.push_back(8'h00);
    total++; if (sram_read !== 1'b0) begin bad++; $display("[TB] FAIL rd_drop: got %b want 0", sram_read); end
    for (int i = 0; i < 3; i++) begin
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
      eb = pop_tx();
      total++; if (tx_valid !== 1'b1 || tx_byte !== eb) begin
        bad++; $display("[TB] FAIL tx_byte%0d: got %b/%h want 1/%h", i, tx_valid, tx_byte, eb);
      end
      total++; if (err_underrun !== (i == 2)) begin
        bad++; $display("[TB] FAIL underrun%0d: got %b want %b", i, err_underrun, (i == 2));
      end
    end
    tick();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("[TB] FAIL tx_strobe: got %b want 0", tx_valid); end
    // New underrun in the clearing cycle keeps the flag set
    tx_req  = 1'b1;
    clr_err = 1'b1;
    tick();
    tx_req  = 1'b0;
    clr_err = 1'b0;
    total++; if (err_underrun !== 1'b1) begin bad++; $display("[TB] FAIL clr_vs_event: got %b want 1", err_underrun); end
    pulse_clr();
    total++; if (err_underrun !== 1'b0) begin bad++; $display("[TB] FAIL underrun_clr: got %b want 0", err_underrun); end
  endtask

  task automatic test_read_tx_same_cycle();
    bit seen, is_wr;
    logic [7:0] eb;
    sram_rdata   = 16'h1234;
    fifo_o_empty = 1'b0;
    wait_any(10, seen, is_wr);
    total++; if ({seen, is_wr} !== 2'b10) begin bad++; $display("[TB] FAIL same_rd_grant: got %b want 10", {seen, is_wr}); end
    fifo_o_empty = 1'b1;
    sram_hint = 1'b1;
    tx_req    = 1'b1;
    tick();
    sram_hint = 1'b0;
    tx_req    = 1'b0;
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34);
    eb = pop_tx();
    total++; if (tx_valid !== 1'b1 || tx_byte !== eb) begin
      bad++; $display("[TB] FAIL same_hi: got %b/%h want 1/%h", tx_valid, tx_byte, eb);
    end
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    eb = pop_tx();
    total++; if (tx_byte !== eb || err_underrun !== 1'b0) begin
      bad++; $display("[TB] FAIL same_lo: got %h/%b want %h/0", tx_byte, err_underrun, eb);
    end
  endtask

  task automatic test_back_to_back();
    bit seen, is_wr;
    int n;
    logic [15:0] exp;
    logic [7:0] eb;
    do_reset();
    fifo_i_full  = 1'b1;
    fifo_o_empty = 1'b1;
    send_byte(8'h13, 1'b0);
    send_byte(8'h57, 1'b0);
    send_byte(8'h24, 1'b0);
    send_byte(8'h68, 1'b0);
    exp_wq.push_back(16'h1357);
    exp_wq.push_back(16'h2468);
    sram_rdata   = 16'hCAFE;
    fifo_i_full  = 1'b0;
    fifo_o_empty = 1'b0;
    // Grant 1: write
    wait_any(10, seen, is_wr);
    exp = pop_wq();
    total++; if ({seen, is_wr} !== 2'b11 || sram_wdata !== exp) begin
      bad++; $display("[TB] FAIL arb_first: got %b/%h want 11/%h", {seen, is_wr}, sram_wdata, exp);
    end
    hint_pulse();
    // Grant 2: read
    wait_any(10, seen, is_wr);
    total++; if ({seen, is_wr} !== 2'b10) begin bad++; $display("[TB] FAIL arb_second: got %b want 10", {seen, is_wr}); end
    fifo_o_empty = 1'b1;
    hint_pulse();
    exp_tx.push_back(8'hCA);
    exp_tx.push_back(8'hFE);
    // Grant 3: write, left unanswered until it times out
    wait_any(10, seen, is_wr);
    exp = (exp_wq.size() > 0) ? exp_wq[0] : 16'hxxxx;
    total++; if ({seen, is_wr} !== 2'b11 || sram_wdata !== exp) begin
      bad++; $display("[TB] FAIL arb_third: got %b/%h want 11/%h", {seen, is_wr}, sram_wdata, exp);
    end
    n = 0;
    while (sram_write === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++; if (n != 64) begin bad++; $display("[TB] FAIL tmo_cycles: got %0d want 64", n); end
    total++; if (err_timeout !== 1'b1 || sram_read !== 1'b0) begin
      bad++; $display("[TB] FAIL tmo_abort: got %b/%b want 1/0", err_timeout, sram_read);
    end
    wait_any(10, seen, is_wr);
    exp = pop_wq();
    total++; if ({seen, is_wr} !== 2'b11 || sram_wdata !== exp) begin
      bad++; $display("[TB] FAIL tmo_retry: got %b/%h want 11/%h", {seen, is_wr}, sram_wdata, exp);
    end
    hint_pulse();
    for (int i = 0; i < 2; i++) begin
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
      eb = pop_tx();
      total++; if (tx_valid !== 1'b1 || tx_byte !== eb) begin
        bad++; $display("[TB] FAIL arb_tx%0d: got %b/%h want 1/%h", i, tx_valid, tx_byte, eb);
      end
    end
    pulse_clr();
    total++; if (err_timeout !== 1'b0) begin bad++; $display("[TB] FAIL tmo_clr: got %b want 0", err_timeout); end
    fifo_i_full = 1'b1;
  endtask

  task automatic test_reset_in_wait();
    bit seen, is_wr, any_req;
    fifo_i_full = 1'b1;
    send_byte(8'h5A, 1'b0);
    send_byte(8'h5B, 1'b0);
    fifo_i_full = 1'b0;
    wait_any(10, seen, is_wr);
    total++; if ({seen, is_wr} !== 2'b11) begin bad++; $display("[TB] FAIL rst_wait_grant: got %b want 11", {seen, is_wr}); end
    rst = 1'b1;
    tick();
    total++; if (sram_write !== 1'b0 || sram_wdata !== 16'h0000) begin
      bad++; $display("[TB] FAIL rst_wait_drop: got %b/%h want 0/0000", sram_write, sram_wdata);
    end
    rst = 1'b0;
    sram_hint = 1'b1;
    tick();
    sram_hint = 1'b0;
    any_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (sram_write === 1'b1 || sram_read === 1'b1) any_req = 1'b1;
      tick();
    end
    total++; if (any_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_late_hint: got %b want 0", any_req); end
    total++; if ({err_overflow, err_underrun, err_timeout} !== 3'b000) begin
      bad++; $display("[TB] FAIL rst_wait_errs: got %b want 000", {err_overflow, err_underrun, err_timeout});
    end
    fifo_i_full = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    rx_byte      = 8'h00;
    rx_valid     = 1'b0;
    rx_flush     = 1'b0;
    tx_req       = 1'b0;
    sram_rdata   = 16'h0000;
    sram_hint    = 1'b0;
    fifo_i_full  = 1'b1;
    fifo_o_empty = 1'b1;
    clr_err      = 1'b0;

    test_reset();
    test_write_handshake();
    test_flush();
    test_overflow();
    test_read_underrun();
    test_read_tx_same_cycle();
    test_back_to_back();
    test_reset_in_wait();

    total++; if (mutex_viol !== 1'b0) begin bad++; $display("[TB] FAIL req_mutex: got %b want 0", mutex_viol); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
